// File: rtl/rv32i_lsu_pkg.sv
// Shared types and helpers for the RV32I load/store unit.
package rv32i_lsu_pkg;

    typedef enum logic [1:0] {
        LOAD     = 2'b00,
        STORE    = 2'b01,
        MEM_NOOP = 2'b11
    } mem_op_t;

    typedef enum logic [1:0] {
        BYTE      = 2'b00,
        HALF_WORD = 2'b01,
        WORD      = 2'b10
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        RESP
    } lsu_state_t;

    // Access fault: illegal op code, or a load/store with an illegal size
    // or an address not aligned to its size. MEM_NOOP never faults.
    function automatic logic lsu_fault(input logic [1:0] op,
                                       input logic [1:0] size,
                                       input logic [1:0] addr_lo);
        logic f;
        f = 1'b0;
        case (op)
            2'b10:   f = 1'b1;
            2'b11:   f = 1'b0;
            default: begin
                case (size)
                    2'b00:   f = 1'b0;
                    2'b01:   f = addr_lo[0];
                    2'b10:   f = |addr_lo;
                    default: f = 1'b1;
                endcase
            end
        endcase
        return f;
    endfunction

endpackage

// File: rtl/rv32i_lsu_align.sv
// Byte-lane steering for the LSU: byte enables, store replication and
// load extract/extend.
module rv32i_lsu_align
    import rv32i_lsu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [1:0]      size_i,
    input  logic [1:0]      addr_lo_i,
    input  logic            load_unsigned_i,
    input  logic [XLEN-1:0] store_data_i,
    input  logic [XLEN-1:0] rdata_i,
    output logic [3:0]      be_o,
    output logic [XLEN-1:0] wdata_o,
    output logic [XLEN-1:0] load_data_o
);

    logic [XLEN-1:0] shifted;

    // Store side: byte enables shifted into the addressed lanes, data replicated
    always_comb begin
        be_o    = '0;
        wdata_o = '0;
        case (mem_size_t'(size_i))
            BYTE: begin
                be_o    = 4'b0001 << addr_lo_i;
                wdata_o = {4{store_data_i[7:0]}};
            end
            HALF_WORD: begin
                be_o    = 4'b0011 << addr_lo_i;
                wdata_o = {2{store_data_i[15:0]}};
            end
            WORD: begin
                be_o    = 4'b1111;
                wdata_o = store_data_i;
            end
            default: ;
        endcase
    end

    // Load side: shift the addressed lane down, then sign- or zero-extend
    always_comb begin
        shifted     = rdata_i >> {addr_lo_i, 3'b000};
        load_data_o = '0;
        case (mem_size_t'(size_i))
            BYTE: begin
                load_data_o = load_unsigned_i ? {{(XLEN-8){1'b0}}, shifted[7:0]}
                                              : {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            end
            HALF_WORD: begin
                load_data_o = load_unsigned_i ? {{(XLEN-16){1'b0}}, shifted[15:0]}
                                              : {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            end
            WORD:    load_data_o = shifted;
            default: ;
        endcase
    end

endmodule

// File: rtl/rv32i_lsu.sv
// Memory stage of the multicycle RV32I core: accepts one op from execute,
// runs the data-memory req/gnt/rvalid transaction and presents a one-cycle
// writeback result.
module rv32i_lsu
    import rv32i_lsu_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid_i,
    output logic              ex_ready_o,
    input  logic [1:0]        mem_op_i,
    input  logic [1:0]        mem_size_i,
    input  logic              load_unsigned_i,
    input  logic [XLEN-1:0]   addr_i,
    input  logic [XLEN-1:0]   store_data_i,
    input  logic [REG_AW-1:0] rd_i,
    input  logic              wb_en_i,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [XLEN-1:0]   dmem_addr_o,
    output logic [3:0]        dmem_be_o,
    output logic [XLEN-1:0]   dmem_wdata_o,
    input  logic              dmem_gnt_i,
    input  logic              dmem_rvalid_i,
    input  logic [XLEN-1:0]   dmem_rdata_i,
    output logic              wb_valid_o,
    output logic              wb_en_o,
    output logic [REG_AW-1:0] wb_rd_o,
    output logic [XLEN-1:0]   wb_data_o,
    output logic              misaligned_o
);

    lsu_state_t        state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic [1:0]        size_q, size_d;
    logic              unsigned_q, unsigned_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic [XLEN-1:0]   sdata_q, sdata_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic              wb_en_q, wb_en_d;
    logic              fault_q, fault_d;
    logic [XLEN-1:0]   rdata_q, rdata_d;

    logic [3:0]        be;
    logic [XLEN-1:0]   wdata;
    logic [XLEN-1:0]   load_data;

    rv32i_lsu_align #(
        .XLEN(XLEN)
    ) u_align (
        .size_i          (size_q),
        .addr_lo_i       (addr_q[1:0]),
        .load_unsigned_i (unsigned_q),
        .store_data_i    (sdata_q),
        .rdata_i         (rdata_q),
        .be_o            (be),
        .wdata_o         (wdata),
        .load_data_o     (load_data)
    );

    // State and latched-operation registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            op_q       <= '0;
            size_q     <= '0;
            unsigned_q <= 1'b0;
            addr_q     <= '0;
            sdata_q    <= '0;
            rd_q       <= '0;
            wb_en_q    <= 1'b0;
            fault_q    <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            size_q     <= size_d;
            unsigned_q <= unsigned_d;
            addr_q     <= addr_d;
            sdata_q    <= sdata_d;
            rd_q       <= rd_d;
            wb_en_q    <= wb_en_d;
            fault_q    <= fault_d;
            rdata_q    <= rdata_d;
        end
    end

    // Next-state logic: accept in IDLE, handshake in REQ/WAIT, one RESP cycle
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        size_d     = size_q;
        unsigned_d = unsigned_q;
        addr_d     = addr_q;
        sdata_d    = sdata_q;
        rd_d       = rd_q;
        wb_en_d    = wb_en_q;
        fault_d    = fault_q;
        rdata_d    = rdata_q;
        case (state_q)
            IDLE: begin
                if (ex_valid_i) begin
                    op_d       = mem_op_i;
                    size_d     = mem_size_i;
                    unsigned_d = load_unsigned_i;
                    addr_d     = addr_i;
                    sdata_d    = store_data_i;
                    rd_d       = rd_i;
                    wb_en_d    = wb_en_i;
                    fault_d    = lsu_fault(mem_op_i, mem_size_i, addr_i[1:0]);
                    rdata_d    = '0;
                    if (fault_d || (mem_op_i == MEM_NOOP)) begin
                        state_d = RESP;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (dmem_gnt_i) begin
                    if (op_q == STORE) begin
                        state_d = RESP;
                    end else if (dmem_rvalid_i) begin
                        rdata_d = dmem_rdata_i;
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (dmem_rvalid_i) begin
                    rdata_d = dmem_rdata_i;
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Moore outputs; bus and writeback fields are zero outside their states
    always_comb begin
        ex_ready_o   = (state_q == IDLE);
        dmem_req_o   = 1'b0;
        dmem_we_o    = 1'b0;
        dmem_addr_o  = '0;
        dmem_be_o    = '0;
        dmem_wdata_o = '0;
        wb_valid_o   = 1'b0;
        wb_en_o      = 1'b0;
        wb_rd_o      = '0;
        wb_data_o    = '0;
        misaligned_o = 1'b0;
        if (state_q == REQ) begin
            dmem_req_o   = 1'b1;
            dmem_we_o    = (op_q == STORE);
            dmem_addr_o  = {addr_q[XLEN-1:2], 2'b00};
            dmem_be_o    = be;
            dmem_wdata_o = wdata;
        end
        if (state_q == RESP) begin
            wb_valid_o   = 1'b1;
            wb_rd_o      = rd_q;
            misaligned_o = fault_q;
            if (!fault_q) begin
                case (op_q)
                    LOAD: begin
                        wb_en_o   = wb_en_q;
                        wb_data_o = load_data;
                    end
                    MEM_NOOP: begin
                        wb_en_o   = wb_en_q;
                        wb_data_o = addr_q;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rv32i_lsu.sv
// Directed self-checking bench for rv32i_lsu.
module tb_rv32i_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid_i;
    logic        ex_ready_o;
    logic [1:0]  mem_op_i;
    logic [1:0]  mem_size_i;
    logic        load_unsigned_i;
    logic [31:0] addr_i;
    logic [31:0] store_data_i;
    logic [4:0]  rd_i;
    logic        wb_en_i;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_gnt_i;
    logic        dmem_rvalid_i;
    logic [31:0] dmem_rdata_i;
    logic        wb_valid_o;
    logic        wb_en_o;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_data_o;
    logic        misaligned_o;

    int unsigned vectors    = 0;
    int unsigned miscompares = 0;

    always #5 clk = ~clk;

    rv32i_lsu #(
        .XLEN   (32),
        .REG_AW (5)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .ex_valid_i      (ex_valid_i),
        .ex_ready_o      (ex_ready_o),
        .mem_op_i        (mem_op_i),
        .mem_size_i      (mem_size_i),
        .load_unsigned_i (load_unsigned_i),
        .addr_i          (addr_i),
        .store_data_i    (store_data_i),
        .rd_i            (rd_i),
        .wb_en_i         (wb_en_i),
        .dmem_req_o      (dmem_req_o),
        .dmem_we_o       (dmem_we_o),
        .dmem_addr_o     (dmem_addr_o),
        .dmem_be_o       (dmem_be_o),
        .dmem_wdata_o    (dmem_wdata_o),
        .dmem_gnt_i      (dmem_gnt_i),
        .dmem_rvalid_i   (dmem_rvalid_i),
        .dmem_rdata_i    (dmem_rdata_i),
        .wb_valid_o      (wb_valid_o),
        .wb_en_o         (wb_en_o),
        .wb_rd_o         (wb_rd_o),
        .wb_data_o       (wb_data_o),
        .misaligned_o    (misaligned_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] sd,
                         input logic [4:0] rd, input logic wen);
        ex_valid_i      = 1'b1;
        mem_op_i        = op;
        mem_size_i      = size;
        load_unsigned_i = uns;
        addr_i          = addr;
        store_data_i    = sd;
        rd_i            = rd;
        wb_en_i         = wen;
        tick();
        ex_valid_i = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        ex_valid_i = 1'b0; mem_op_i = '0; mem_size_i = '0; load_unsigned_i = 1'b0;
        addr_i = '0; store_data_i = '0; rd_i = '0; wb_en_i = 1'b0;
        dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
        tick();
        tick();

        // Reset state
        chk("rst_ready", 32'(ex_ready_o), 32'h1);
        chk("rst_req", 32'(dmem_req_o), 32'h0);
        chk("rst_addr", dmem_addr_o, 32'h0);
        chk("rst_be", 32'(dmem_be_o), 32'h0);
        chk("rst_wdata", dmem_wdata_o, 32'h0);
        chk("rst_wbvalid", 32'(wb_valid_o), 32'h0);
        chk("rst_wbdata", wb_data_o, 32'h0);
        chk("rst_misal", 32'(misaligned_o), 32'h0);
        rst = 1'b0;
        tick();

        // SW 0x104 <- 0xDEADBEEF, gnt on first request cycle
        dmem_gnt_i = 1'b1;
        issue(2'b01, 2'b10, 1'b0, 32'h0000_0104, 32'hDEAD_BEEF, 5'd3, 1'b1);
        chk("sw_req", 32'(dmem_req_o), 32'h1);
        chk("sw_we", 32'(dmem_we_o), 32'h1);
        chk("sw_addr", dmem_addr_o, 32'h0000_0104);
        chk("sw_be", 32'(dmem_be_o), 32'hF);
        chk("sw_wdata", dmem_wdata_o, 32'hDEAD_BEEF);
        chk("sw_ready", 32'(ex_ready_o), 32'h0);
        chk("sw_wbv_early", 32'(wb_valid_o), 32'h0);
        tick();
        chk("sw_wbvalid", 32'(wb_valid_o), 32'h1);
        chk("sw_wben", 32'(wb_en_o), 32'h0);
        chk("sw_wbdata", wb_data_o, 32'h0);
        chk("sw_req_off", 32'(dmem_req_o), 32'h0);
        dmem_gnt_i = 1'b0;
        tick();
        chk("sw_wbv_pulse", 32'(wb_valid_o), 32'h0);
        chk("sw_ready_back", 32'(ex_ready_o), 32'h1);

        // LB 0x203, rvalid one cycle after gnt
        dmem_gnt_i = 1'b1;
        dmem_rdata_i = 32'h8011_2233;
        issue(2'b00, 2'b00, 1'b0, 32'h0000_0203, 32'h0, 5'd7, 1'b1);
        chk("lb_be", 32'(dmem_be_o), 32'h8);
        chk("lb_addr", dmem_addr_o, 32'h0000_0200);
        chk("lb_we", 32'(dmem_we_o), 32'h0);
        tick();
        dmem_gnt_i = 1'b0;
        chk("lb_wait_req", 32'(dmem_req_o), 32'h0);
        chk("lb_wait_wbv", 32'(wb_valid_o), 32'h0);
        dmem_rvalid_i = 1'b1;
        tick();
        dmem_rvalid_i = 1'b0;
        chk("lb_wbvalid", 32'(wb_valid_o), 32'h1);
        chk("lb_wbdata", wb_data_o, 32'hFFFF_FF80);
        chk("lb_wben", 32'(wb_en_o), 32'h1);
        chk("lb_wbrd", 32'(wb_rd_o), 32'd7);
        tick();

        // LBU 0x203, gnt and rvalid together (stale rvalid at accept ignored)
        dmem_gnt_i = 1'b1;
        dmem_rvalid_i = 1'b1;
        issue(2'b00, 2'b00, 1'b1, 32'h0000_0203, 32'h0, 5'd8, 1'b1);
        chk("lbu_req", 32'(dmem_req_o), 32'h1);
        tick();
        dmem_gnt_i = 1'b0;
        dmem_rvalid_i = 1'b0;
        chk("lbu_wbvalid", 32'(wb_valid_o), 32'h1);
        chk("lbu_wbdata", wb_data_o, 32'h0000_0080);
        tick();

        // LH 0x202, gnt delayed 3 cycles, rvalid 2 cycles after gnt
        dmem_rdata_i = 32'hF00D_1234;
        issue(2'b00, 2'b01, 1'b0, 32'h0000_0202, 32'h5555_AAAA, 5'd9, 1'b1);
        for (int i = 0; i < 3; i++) begin
            chk("lh_hold_req", 32'(dmem_req_o), 32'h1);
            chk("lh_hold_addr", dmem_addr_o, 32'h0000_0200);
            chk("lh_hold_be", 32'(dmem_be_o), 32'hC);
            chk("lh_hold_ready", 32'(ex_ready_o), 32'h0);
            tick();
        end
        dmem_gnt_i = 1'b1;
        chk("lh_gnt_req", 32'(dmem_req_o), 32'h1);
        chk("lh_gnt_wdata", dmem_wdata_o, 32'hAAAA_AAAA);
        tick();
        dmem_gnt_i = 1'b0;
        chk("lh_wait_req", 32'(dmem_req_o), 32'h0);
        chk("lh_wait_ready", 32'(ex_ready_o), 32'h0);
        tick();
        dmem_rvalid_i = 1'b1;
        chk("lh_wait2_wbv", 32'(wb_valid_o), 32'h0);
        tick();
        dmem_rvalid_i = 1'b0;
        chk("lh_wbvalid", 32'(wb_valid_o), 32'h1);
        chk("lh_wbdata", wb_data_o, 32'hFFFF_F00D);
        chk("lh_resp_ready", 32'(ex_ready_o), 32'h0);
        tick();
        chk("lh_ready_back", 32'(ex_ready_o), 32'h1);

        // LW 0x101: misaligned fault, no bus request
        issue(2'b00, 2'b10, 1'b0, 32'h0000_0101, 32'h0, 5'd4, 1'b1);
        chk("lw_mis_req", 32'(dmem_req_o), 32'h0);
        chk("lw_mis_wbv", 32'(wb_valid_o), 32'h1);
        chk("lw_mis_flag", 32'(misaligned_o), 32'h1);
        chk("lw_mis_wben", 32'(wb_en_o), 32'h0);
        tick();
        chk("lw_mis_clear", 32'(misaligned_o), 32'h0);

        // Illegal op code 10 faults
        issue(2'b10, 2'b00, 1'b0, 32'h0000_0000, 32'h0, 5'd4, 1'b1);
        chk("op10_flag", 32'(misaligned_o), 32'h1);
        chk("op10_req", 32'(dmem_req_o), 32'h0);
        tick();

        // SB 0x2 <- 0xAB
        dmem_gnt_i = 1'b1;
        issue(2'b01, 2'b00, 1'b0, 32'h0000_0002, 32'h0000_00AB, 5'd0, 1'b0);
        chk("sb_be", 32'(dmem_be_o), 32'h4);
        chk("sb_wdata", dmem_wdata_o, 32'hABAB_ABAB);
        chk("sb_addr", dmem_addr_o, 32'h0);
        tick();
        dmem_gnt_i = 1'b0;
        chk("sb_wbvalid", 32'(wb_valid_o), 32'h1);
        tick();

        // MEM_NOOP pass-through
        issue(2'b11, 2'b00, 1'b0, 32'h1234_5678, 32'h0, 5'd5, 1'b1);
        chk("noop_req", 32'(dmem_req_o), 32'h0);
        chk("noop_wbvalid", 32'(wb_valid_o), 32'h1);
        chk("noop_wbdata", wb_data_o, 32'h1234_5678);
        chk("noop_wbrd", 32'(wb_rd_o), 32'd5);
        chk("noop_wben", 32'(wb_en_o), 32'h1);
        chk("noop_misal", 32'(misaligned_o), 32'h0);
        tick();

        // Reset while waiting for rvalid, then a late rvalid
        dmem_gnt_i = 1'b1;
        issue(2'b00, 2'b10, 1'b0, 32'h0000_0300, 32'h0, 5'd6, 1'b1);
        tick();
        dmem_gnt_i = 1'b0;
        chk("rstw_in_wait_req", 32'(dmem_req_o), 32'h0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        dmem_rvalid_i = 1'b1;
        chk("rstw_ready", 32'(ex_ready_o), 32'h1);
        chk("rstw_wbv", 32'(wb_valid_o), 32'h0);
        tick();
        dmem_rvalid_i = 1'b0;
        chk("rstw_late_wbv", 32'(wb_valid_o), 32'h0);
        chk("rstw_late_ready", 32'(ex_ready_o), 32'h1);
        chk("rstw_late_req", 32'(dmem_req_o), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rv32i_lsu.md
Name: rv32i_lsu

Overview:
- Memory stage of the multicycle RV32I core. It sits directly downstream of execute and upstream of writeback.
- Consumes the decoded memory op (LOAD/STORE/MEM_NOOP), access size, effective address from the ADD_MEM ALU result, store data and destination register.
- Runs a request/grant/response transaction on the data-memory port.
- Hands writeback a single-cycle result: aligned/extended load data, or the pass-through ALU result for non-memory instructions.

Parameters:
- XLEN, 32, data/address width; only 32 is supported.
- REG_AW, 5, register index width.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- ex_valid_i  in  1  execute presents an op
- ex_ready_o  out  1  LSU accepts an op this cycle
- mem_op_i  in  2  LOAD=00, STORE=01, MEM_NOOP=11
- mem_size_i  in  2  BYTE=00, HALF_WORD=01, WORD=10
- load_unsigned_i  in  1  1 = zero-extend load (LBU/LHU)
- addr_i  in  XLEN  effective address, or ALU result when MEM_NOOP
- store_data_i  in  XLEN  rs2 value
- rd_i  in  REG_AW  destination register
- wb_en_i  in  1  WB_EN / WB_NOOP from decode
- dmem_req_o  out  1  bus request
- dmem_we_o  out  1  1 = write
- dmem_addr_o  out  XLEN  word address, bits[1:0]=00
- dmem_be_o  out  4  byte enables
- dmem_wdata_o  out  XLEN  lane-replicated store data
- dmem_gnt_i  in  1  request accepted
- dmem_rvalid_i  in  1  read data valid
- dmem_rdata_i  in  XLEN  read data
- wb_valid_o  out  1  result valid (one-cycle pulse)
- wb_en_o  out  1  register write enable
- wb_rd_o  out  REG_AW  destination register
- wb_data_o  out  XLEN  writeback data
- misaligned_o  out  1  access fault, qualified by wb_valid_o

Behaviour:
- Reset: synchronous, active-high.
  - State IDLE.
  - ex_ready_o=1.
  - All other outputs 0, including dmem_addr_o/be/wdata and wb_data_o.
- FSM states and transitions:
  - IDLE: ex_ready_o=1. On ex_valid_i, latch all inputs.
    - MEM_NOOP goes to RESP.
    - Fault goes to RESP.
    - LOAD/STORE go to REQ.
  - REQ: dmem_req_o=1. addr/we/be/wdata are held stable until gnt.
    - STORE with gnt goes to RESP.
    - LOAD with gnt and no rvalid goes to WAIT.
    - LOAD with gnt and rvalid in the same cycle captures rdata and goes to RESP.
  - WAIT: dmem_req_o=0. On rvalid, capture rdata and go to RESP.
  - RESP: wb_valid_o=1 for exactly one cycle, then go to IDLE. ex_ready_o=0 in every state except IDLE.
- Latency, assuming zero-wait memory:
  - MEM_NOOP: 2 cycles from accept to wb_valid_o.
  - Store: 3 cycles.
  - Load: 4 cycles, or 3 with same-cycle gnt+rvalid.
- Fault rules:
  - HALF_WORD with addr[0]=1 faults.
  - WORD with addr[1:0]≠00 faults.
  - mem_size=11 faults.
  - mem_op=10 faults.
  - On a fault: no bus request, misaligned_o=1, wb_en_o=0.
- Byte enables:
  - BYTE: 0001<<addr[1:0].
  - HALF_WORD: 0011<<addr[1:0].
  - WORD: 1111.
- Store data lanes:
  - BYTE: {4{d[7:0]}}.
  - HALF_WORD: {2{d[15:0]}}.
  - WORD: d.
- Load extract: shift rdata right by 8*addr[1:0], take 8/16/32 bits, then sign- or zero-extend per load_unsigned_i.
- Writeback data:
  - Loads: extracted value.
  - MEM_NOOP: latched addr_i.
  - Stores: 0, with wb_en_o forced to 0.
- wb_en_o = latched wb_en_i for loads and MEM_NOOP.
- wb_rd_o is the latched rd. When rd=0, wb_en_o is still passed through; the regfile ignores x0.
- dmem_rvalid_i outside REQ/WAIT is ignored (stale response after reset).
- Reset mid-transaction: return to IDLE next edge, drop dmem_req_o, no wb_valid_o.

Decomposition:
- RV32I_core_utils_package gains:
  - mem_op_t enum with distinct LOAD/STORE/MEM_NOOP codes, with no LOAD_SIGN_EXTEND alias.
  - mem_size_t.
  - lsu_state_t {IDLE, REQ, WAIT, RESP}.
  - The fault-detect function.
- One combinational sub-module, rv32i_lsu_align, holds the byte-enable, store replication and load extract/extend logic. The FSM stays in rv32i_lsu.

Test Plan:
- SW addr 0x104, data 0xDEADBEEF, gnt same cycle → req/we=1, dmem_addr=0x104, be=1111, wdata=0xDEADBEEF; wb_valid after 3 cycles, wb_en_o=0.
- LB addr 0x203, rdata 0x80112233 → be=1000, wb_data=0xFFFFFF80; repeat as LBU → 0x00000080.
- LH addr 0x202, rdata 0xF00D1234, gnt delayed 3 cycles, rvalid 2 cycles later → req held with stable outputs for 4 cycles; wb_data=0xFFFFF00D; ex_ready_o=0 until RESP has passed.
- LW addr 0x101 → no dmem_req_o, wb_valid_o with misaligned_o=1, wb_en_o=0.
- SB addr 0x2, data 0x000000AB → be=0100, wdata=0xABABABAB.
- MEM_NOOP addr_i 0x12345678, rd=5, wb_en=1 → wb_valid 2 cycles later, wb_data=0x12345678, wb_rd=5.
- Assert rst during WAIT, then raise rvalid → no wb_valid_o, state IDLE, ex_ready_o=1.
